// File: rtl/frame_stretch_stats.sv
// Per-frame min/max scan with a serial restoring divider that turns the
// frame's [min, max] range into a shift/gain pair for the contrast stretch.
module frame_stretch_stats #(
    parameter int FRAC     = 15,
    parameter int GAIN_MAX = 131071
) (
    input  logic        vin_clk_i,
    input  logic        rst_i,
    input  logic        vin_vs_i,
    input  logic        vin_de_i,
    input  logic [23:0] vin_data_i,
    input  logic        inv_en_i,
    input  logic        auto_en_i,
    output logic [29:0] shift_o,
    output logic [17:0] gain_o,
    output logic        upd_o,
    output logic        busy_o
);
    // state   | meaning
    // S_IDLE  | accumulating pixels, waiting for a vs rising edge
    // S_CHECK | pick bypass (unity) or set up the divider
    // S_DIV   | 23 restoring-division steps, MSB first
    // S_PUB   | register shift/gain, pulse upd_o
    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_DIV, S_PUB} state_t;

    localparam logic [17:0] GAIN_UNITY = 18'(1 << FRAC);
    localparam logic [22:0] DIVIDEND   = 23'(255 << FRAC);
    localparam logic [22:0] GAIN_SAT   = 23'(GAIN_MAX);

    state_t      state_q, state_d;
    logic        vs_q;
    logic [7:0]  mn_q, mx_q, smn_q, smx_q, range_q;
    logic        auto_q, byp_q;
    logic [22:0] quo_q;
    logic [7:0]  rem_q, rem_d;
    logic [4:0]  cnt_q;
    logic [29:0] shift_q;
    logic [17:0] gain_q;

    logic [7:0]  v0, v1, v2, pmn, pmx;
    logic        bnd, take, bypass, qbit;
    logic [8:0]  trial, diff;

    always_comb begin
        v0  = vin_data_i[23:16] ^ {8{inv_en_i}};
        v1  = vin_data_i[15:8]  ^ {8{inv_en_i}};
        v2  = vin_data_i[7:0]   ^ {8{inv_en_i}};
        pmn = v0;
        pmx = v0;
        if (v1 < pmn) pmn = v1;
        if (v2 < pmn) pmn = v2;
        if (v1 > pmx) pmx = v1;
        if (v2 > pmx) pmx = v2;
    end

    assign bnd    = vin_vs_i & ~vs_q;
    assign take   = bnd && (state_q == S_IDLE);
    assign bypass = ~auto_q || (smx_q <= smn_q);

    always_comb begin
        trial = {rem_q, quo_q[22]};
        diff  = trial - {1'b0, range_q};
        qbit  = 1'b0;
        rem_d = trial[7:0];
        if (trial >= {1'b0, range_q}) begin
            qbit  = 1'b1;
            rem_d = diff[7:0];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (take) state_d = S_CHECK;
            S_CHECK: state_d = bypass ? S_PUB : S_DIV;
            S_DIV:   if (cnt_q == 5'd0) state_d = S_PUB;
            S_PUB:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge vin_clk_i or posedge rst_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // A pixel on the boundary cycle seeds the new frame's accumulators.
    always_ff @(posedge vin_clk_i or posedge rst_i) begin
        if (rst_i) begin
            vs_q   <= 1'b0;
            mn_q   <= 8'hFF;
            mx_q   <= 8'h00;
            smn_q  <= 8'hFF;
            smx_q  <= 8'h00;
            auto_q <= 1'b0;
        end else begin
            vs_q <= vin_vs_i;
            if (take) begin
                smn_q  <= mn_q;
                smx_q  <= mx_q;
                auto_q <= auto_en_i;
                mn_q   <= vin_de_i ? pmn : 8'hFF;
                mx_q   <= vin_de_i ? pmx : 8'h00;
            end else if (vin_de_i) begin
                if (pmn < mn_q) mn_q <= pmn;
                if (pmx > mx_q) mx_q <= pmx;
            end
        end
    end

    always_ff @(posedge vin_clk_i or posedge rst_i) begin
        if (rst_i) begin
            byp_q   <= 1'b1;
            range_q <= 8'd0;
            quo_q   <= 23'd0;
            rem_q   <= 8'd0;
            cnt_q   <= 5'd0;
            shift_q <= 30'd0;
            gain_q  <= GAIN_UNITY;
        end else begin
            case (state_q)
                S_CHECK: begin
                    byp_q   <= bypass;
                    range_q <= smx_q - smn_q;
                    quo_q   <= DIVIDEND;
                    rem_q   <= 8'd0;
                    cnt_q   <= 5'd22;
                end
                S_DIV: begin
                    quo_q <= {quo_q[21:0], qbit};
                    rem_q <= rem_d;
                    cnt_q <= cnt_q - 5'd1;
                end
                S_PUB: begin
                    if (byp_q) begin
                        gain_q  <= GAIN_UNITY;
                        shift_q <= 30'd0;
                    end else begin
                        gain_q  <= (quo_q > GAIN_SAT) ? GAIN_SAT[17:0] : quo_q[17:0];
                        shift_q <= {22'd0, smn_q};
                    end
                end
                default: ;
            endcase
        end
    end

    assign shift_o = shift_q;
    assign gain_o  = gain_q;
    assign upd_o   = (state_q == S_PUB);
    assign busy_o  = (state_q != S_IDLE);

endmodule

// File: tb/tb_frame_stretch_stats.sv
// Directed bench for frame_stretch_stats: hand-computed shift/gain, update
// latency, dropped boundaries and reset abort.
module tb_frame_stretch_stats;
    logic        clk_sys = 1'b0;
    logic        rst_i;
    logic        vin_vs_i, vin_de_i, inv_en_i, auto_en_i;
    logic [23:0] vin_data_i;
    logic [29:0] shift_o;
    logic [17:0] gain_o;
    logic        upd_o, busy_o;

    int n_checks = 0;
    int n_errors = 0;

    frame_stretch_stats dut (
        .vin_clk_i (clk_sys),
        .rst_i     (rst_i),
        .vin_vs_i  (vin_vs_i),
        .vin_de_i  (vin_de_i),
        .vin_data_i(vin_data_i),
        .inv_en_i  (inv_en_i),
        .auto_en_i (auto_en_i),
        .shift_o   (shift_o),
        .gain_o    (gain_o),
        .upd_o     (upd_o),
        .busy_o    (busy_o)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drives one pixel; entered and left at posedge+1.
    task automatic pix(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        vin_de_i   = 1'b1;
        vin_data_i = {a, b, c};
        @(posedge clk_sys); #1;
        vin_de_i   = 1'b0;
    endtask

    // Raises vs, watches 30 cycles for the update. With inject set, a second
    // vs edge carrying a pixel of 30s arrives 9-10 cycles into the divide.
    task automatic frame_check(input string tag, input int exp_shift, input int exp_gain,
                               input int exp_lat, input bit inject);
        int first_upd = -1;
        int n_upd = 0;
        logic busy_k1;
        vin_vs_i = 1'b1;
        @(posedge clk_sys);
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk_sys);
            if (k == 1) busy_k1 = busy_o;
            if (upd_o) begin
                n_upd++;
                if (first_upd < 0) first_upd = k;
            end
            if (k == 2) vin_vs_i = 1'b0;
            if (inject && k == 9) begin
                vin_vs_i   = 1'b1;
                vin_de_i   = 1'b1;
                vin_data_i = 24'h1E1E1E;
            end
            if (inject && k == 10) begin
                vin_vs_i = 1'b0;
                vin_de_i = 1'b0;
            end
        end
        check_val({tag, "_busy"}, 32'(busy_k1), 32'd1);
        check_val({tag, "_lat"}, 32'(first_upd), 32'(exp_lat));
        check_val({tag, "_nupd"}, 32'(n_upd), 32'd1);
        check_val({tag, "_shift"}, 32'(shift_o), 32'(exp_shift));
        check_val({tag, "_gain"}, 32'(gain_o), 32'(exp_gain));
        @(posedge clk_sys); #1;
    endtask

    initial begin
        int n_upd;
        rst_i      = 1'b1;
        vin_vs_i   = 1'b0;
        vin_de_i   = 1'b0;
        vin_data_i = 24'd0;
        inv_en_i   = 1'b0;
        auto_en_i  = 1'b1;
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        check_val("rst_shift", 32'(shift_o), 32'd0);
        check_val("rst_gain", 32'(gain_o), 32'd32768);
        check_val("rst_upd", 32'(upd_o), 32'd0);
        check_val("rst_busy", 32'(busy_o), 32'd0);
        @(posedge clk_sys); #1;
        rst_i = 1'b0;
        @(posedge clk_sys); #1;

        pix(8'd16, 8'd100, 8'd235);
        pix(8'd50, 8'd60, 8'd70);
        frame_check("span", 16, 38154, 25, 1'b0);

        inv_en_i = 1'b1;
        pix(8'd16, 8'd100, 8'd235);
        pix(8'd50, 8'd60, 8'd70);
        frame_check("inv", 20, 38154, 25, 1'b0);
        inv_en_i = 1'b0;

        pix(8'h80, 8'h80, 8'h80);
        pix(8'h80, 8'h80, 8'h80);
        frame_check("flat", 0, 32768, 2, 1'b0);
        frame_check("empty", 0, 32768, 2, 1'b0);

        pix(8'd100, 8'd120, 8'd150);
        frame_check("sat", 100, 131071, 25, 1'b0);

        auto_en_i = 1'b0;
        pix(8'd16, 8'd100, 8'd235);
        frame_check("bypass", 0, 32768, 2, 1'b0);
        auto_en_i = 1'b1;

        pix(8'd100, 8'd110, 8'd120);
        frame_check("drop1", 100, 131071, 25, 1'b1);
        pix(8'd200, 8'd200, 8'd200);
        frame_check("merge", 30, 49152, 25, 1'b0);

        pix(8'd16, 8'd100, 8'd235);
        vin_vs_i = 1'b1;
        @(posedge clk_sys);
        n_upd = 0;
        repeat (10) begin
            @(negedge clk_sys);
            if (upd_o) n_upd++;
        end
        check_val("abort_busy_pre", 32'(busy_o), 32'd1);
        rst_i    = 1'b1;
        vin_vs_i = 1'b0;
        #1;
        check_val("abort_shift", 32'(shift_o), 32'd0);
        check_val("abort_gain", 32'(gain_o), 32'd32768);
        check_val("abort_busy", 32'(busy_o), 32'd0);
        @(posedge clk_sys); #1;
        rst_i = 1'b0;
        repeat (30) begin
            @(negedge clk_sys);
            if (upd_o) n_upd++;
        end
        check_val("abort_nupd", 32'(n_upd), 32'd0);
        check_val("abort_hold_gain", 32'(gain_o), 32'd32768);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        n_errors++;
        $display("FAIL timeout: got no finish expected finish");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1);
    end
endmodule
